// File: rtl/video_timing_gen.sv
// video_timing_gen: pixel clock enable, h/v counters and registered sync/blank timing.
// Define VIDEO_TIMING_GEN_POS_ADJ_EN to enable per-frame hoffs/voffs sync position adjust.
module video_timing_gen #(
   parameter int CE_DIV       = 4,
   parameter int H_TOTAL      = 384,
   parameter int H_ACTIVE     = 256,
   parameter int H_SYNC_START = 288,
   parameter int H_SYNC_WIDTH = 32,
   parameter int V_TOTAL      = 262,
   parameter int V_ACTIVE     = 224,
   parameter int V_SYNC_START = 236,
   parameter int V_SYNC_WIDTH = 3
) (
   input  logic       clk_sys,
   input  logic       reset_n,
   input  logic [3:0] hoffs,
   input  logic [3:0] voffs,
   output logic       ce_pix,
   output logic [8:0] hcnt,
   output logic [8:0] vcnt,
   output logic       HSync,
   output logic       VSync,
   output logic       HBlank,
   output logic       VBlank,
   output logic       line_start,
   output logic       frame_start
);
   localparam int DW = $clog2(CE_DIV);

   logic [DW-1:0] div_q, div_d;
   logic          ce_q;
   logic [8:0]    hcnt_q, hcnt_d, vcnt_q, vcnt_d;
   logic          hs_q, vs_q, hb_q, vb_q, ls_q, fs_q;
   logic          hs_d, vs_d, hb_d, vb_d;
   logic          h_wrap, v_wrap, f_wrap;
   logic [9:0]    hs_start, vs_start, h_diff, v_diff, h_mod, v_mod;

`ifdef VIDEO_TIMING_GEN_POS_ADJ_EN
   logic [3:0]  hoffs_q, hoffs_d, voffs_q, voffs_d;
   logic [10:0] hs_sum, vs_sum;

   // Offsets take effect on the edge that starts the new frame, so use the next value.
   always_comb begin
      hoffs_d  = f_wrap ? hoffs : hoffs_q;
      voffs_d  = f_wrap ? voffs : voffs_q;
      hs_sum   = 11'(H_SYNC_START + H_TOTAL) + {{7{hoffs_d[3]}}, hoffs_d};
      vs_sum   = 11'(V_SYNC_START + V_TOTAL) + {{7{voffs_d[3]}}, voffs_d};
      hs_start = 10'(hs_sum >= 11'(2 * H_TOTAL) ? hs_sum - 11'(2 * H_TOTAL) :
                     hs_sum >= 11'(H_TOTAL) ? hs_sum - 11'(H_TOTAL) : hs_sum);
      vs_start = 10'(vs_sum >= 11'(2 * V_TOTAL) ? vs_sum - 11'(2 * V_TOTAL) :
                     vs_sum >= 11'(V_TOTAL) ? vs_sum - 11'(V_TOTAL) : vs_sum);
   end

   always_ff @(posedge clk_sys or negedge reset_n)
      if (!reset_n) begin
         hoffs_q <= '0;
         voffs_q <= '0;
      end else begin
         hoffs_q <= hoffs_d;
         voffs_q <= voffs_d;
      end
`else
   logic unused_offs;
   assign unused_offs = ^{hoffs, voffs};
   assign hs_start    = 10'(H_SYNC_START);
   assign vs_start    = 10'(V_SYNC_START);
`endif

   always_comb begin
      div_d  = (div_q == DW'(CE_DIV - 1)) ? '0 : div_q + 1'b1;
      h_wrap = hcnt_q == 9'(H_TOTAL - 1);
      v_wrap = vcnt_q == 9'(V_TOTAL - 1);
      f_wrap = ce_q && h_wrap && v_wrap;
      hcnt_d = !ce_q ? hcnt_q : h_wrap ? '0 : hcnt_q + 1'b1;
      vcnt_d = !(ce_q && h_wrap) ? vcnt_q : v_wrap ? '0 : vcnt_q + 1'b1;
      // Bias by the total so the distance from sync start never goes negative.
      h_diff = {1'b0, hcnt_d} + 10'(H_TOTAL) - hs_start;
      v_diff = {1'b0, vcnt_d} + 10'(V_TOTAL) - vs_start;
      h_mod  = h_diff >= 10'(H_TOTAL) ? h_diff - 10'(H_TOTAL) : h_diff;
      v_mod  = v_diff >= 10'(V_TOTAL) ? v_diff - 10'(V_TOTAL) : v_diff;
      hs_d   = h_mod < 10'(H_SYNC_WIDTH);
      vs_d   = v_mod < 10'(V_SYNC_WIDTH);
      hb_d   = hcnt_d >= 9'(H_ACTIVE);
      vb_d   = vcnt_d >= 9'(V_ACTIVE);
   end

   always_ff @(posedge clk_sys or negedge reset_n)
      if (!reset_n) begin
         div_q  <= '0;
         ce_q   <= 1'b0;
         hcnt_q <= '0;
         vcnt_q <= '0;
         hs_q   <= 1'b0;
         vs_q   <= 1'b0;
         hb_q   <= 1'b0;
         vb_q   <= 1'b0;
         ls_q   <= 1'b0;
         fs_q   <= 1'b0;
      end else begin
         div_q  <= div_d;
         ce_q   <= div_q == DW'(CE_DIV - 1);
         hcnt_q <= hcnt_d;
         vcnt_q <= vcnt_d;
         ls_q   <= ce_q && h_wrap;
         fs_q   <= f_wrap;
         if (ce_q) begin
            hs_q <= hs_d;
            vs_q <= vs_d;
            hb_q <= hb_d;
            vb_q <= vb_d;
         end
      end

   assign ce_pix      = ce_q;
   assign hcnt        = hcnt_q;
   assign vcnt        = vcnt_q;
   assign HSync       = hs_q;
   assign VSync       = vs_q;
   assign HBlank      = hb_q;
   assign VBlank      = vb_q;
   assign line_start  = ls_q;
   assign frame_start = fs_q;
endmodule

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen: default instance plus a small-frame instance, checked every cycle
// against an arithmetic timing model, with random offsets and random async reset pulses.
module tb_video_timing_gen;
   logic clk = 1'b0;
   logic rst_n;
   logic [3:0] hoffs, voffs;
   int cyc;
   int pass_cnt = 0, total_cnt = 0;
   bit en = 1'b0;
   int la_ha, la_va, la_hb, la_vb;

   logic ceA, hsA, vsA, hbA, vbA, lsA, fsA;
   logic ceB, hsB, vsB, hbB, vbB, lsB, fsB;
   logic [8:0] hA, vA, hB, vB;
   logic [31:0] actA, actB;

   always #5 clk = ~clk;

   video_timing_gen u_a (
      .clk_sys(clk), .reset_n(rst_n), .hoffs(hoffs), .voffs(voffs),
      .ce_pix(ceA), .hcnt(hA), .vcnt(vA), .HSync(hsA), .VSync(vsA),
      .HBlank(hbA), .VBlank(vbA), .line_start(lsA), .frame_start(fsA)
   );

   video_timing_gen #(
      .CE_DIV(3), .H_TOTAL(40), .H_ACTIVE(30), .H_SYNC_START(36), .H_SYNC_WIDTH(6),
      .V_TOTAL(12), .V_ACTIVE(9), .V_SYNC_START(10), .V_SYNC_WIDTH(3)
   ) u_b (
      .clk_sys(clk), .reset_n(rst_n), .hoffs(hoffs), .voffs(voffs),
      .ce_pix(ceB), .hcnt(hB), .vcnt(vB), .HSync(hsB), .VSync(vsB),
      .HBlank(hbB), .VBlank(vbB), .line_start(lsB), .frame_start(fsB)
   );

   assign actA = {7'd0, ceA, hA, vA, hsA, vsA, hbA, vbA, lsA, fsA};
   assign actB = {7'd0, ceB, hB, vB, hsB, vsB, hbB, vbB, lsB, fsB};

   // Expected outputs after c rising edges since reset release.
   function automatic logic [31:0] model(int c, int ce, int ht, int ha, int hss, int hsw,
                                         int vt, int va, int vss, int vsw, int ho, int vo);
      int n, h, v, h0, v0;
      bit cep, hs, vs, hb, vb, ls, fs;
      n   = (c > ce) ? (c - 1) / ce : 0;
      cep = (c >= ce) && (c % ce == 0);
      h   = n % ht;
      v   = (n / ht) % vt;
      h0  = ((hss + ho) % ht + ht) % ht;
      v0  = ((vss + vo) % vt + vt) % vt;
      hs  = (n > 0) && (((h - h0) % ht + ht) % ht < hsw);
      vs  = (n > 0) && (((v - v0) % vt + vt) % vt < vsw);
      hb  = (n > 0) && (h >= ha);
      vb  = (n > 0) && (v >= va);
      ls  = (n > 0) && ((c - 1) % ce == 0) && (h == 0);
      fs  = ls && (v == 0);
      return {7'd0, cep, 9'(h), 9'(v), hs, vs, hb, vb, ls, fs};
   endfunction

   function automatic bit frame_edge(int c, int ce, int fr);
      return (c > ce) && ((c - 1) % ce == 0) && (((c - 1) / ce) % fr == 0);
   endfunction

   always @(posedge clk or negedge rst_n)
      if (!rst_n) cyc <= 0;
      else cyc <= cyc + 1;

   always @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         la_ha <= 0; la_va <= 0; la_hb <= 0; la_vb <= 0;
      end else begin
`ifdef VIDEO_TIMING_GEN_POS_ADJ_EN
         if (frame_edge(cyc + 1, 4, 384 * 262)) begin
            la_ha <= int'($signed(hoffs));
            la_va <= int'($signed(voffs));
         end
         if (frame_edge(cyc + 1, 3, 40 * 12)) begin
            la_hb <= int'($signed(hoffs));
            la_vb <= int'($signed(voffs));
         end
`endif
      end

   task automatic chk(string name, int act, int exp);
      total_cnt++;
      if (act == exp) pass_cnt++;
      else $display("FAIL %s at cyc %0d: got 0x%0h, want 0x%0h", name, cyc, act, exp);
   endtask

   always @(negedge clk)
      if (en) begin
         chk("A_cycle", actA, model(cyc, 4, 384, 256, 288, 32, 262, 224, 236, 3, la_ha, la_va));
         chk("B_cycle", actB, model(cyc, 3, 40, 30, 36, 6, 12, 9, 10, 3, la_hb, la_vb));
      end

   task automatic wait_cyc(int n);
      int g = 0;
      while (cyc < n && g < 50000) begin
         @(negedge clk);
         g++;
      end
      if (cyc != n) begin
         total_cnt++;
         $display("FAIL wait_cyc: got cyc %0d, want %0d", cyc, n);
      end
   endtask

   task automatic reset_pulse();
      @(posedge clk);
      #($urandom_range(1, 4));
      rst_n = 1'b0;
      #1;
      chk("async_rst_A", actA, 0);
      chk("async_rst_B", actB, 0);
      repeat ($urandom_range(1, 3)) @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      hoffs = 4'd0;
      voffs = 4'd0;
      #1 en = 1'b1;
      repeat (3) @(negedge clk);
      chk("reset_A", actA, 0);
      chk("reset_B", actB, 0);
      rst_n = 1'b1;
      wait_cyc(3);    chk("ce_c3", int'(ceA), 0);
      wait_cyc(4);    chk("ce_c4", int'(ceA), 1);
      wait_cyc(5);    chk("ce_c5", int'(ceA), 0); chk("hcnt_c5", int'(hA), 1);
      wait_cyc(8);    chk("ce_c8", int'(ceA), 1);
      wait_cyc(85);   chk("B_hs_h28_f0", int'(hsB), 0);
      wait_cyc(124);  chk("B_hs_wrap_h1", int'(hsB), 1);
      wait_cyc(127);  chk("B_hs_wrap_h2", int'(hsB), 0);
      wait_cyc(300);
      hoffs = 4'b1000;
      voffs = 4'd2;
      wait_cyc(1024); chk("hb_h255", int'(hbA), 0); chk("hcnt_255", int'(hA), 255);
      wait_cyc(1025); chk("hb_h256", int'(hbA), 1); chk("hcnt_256", int'(hA), 256);
      wait_cyc(1152); chk("hs_h287", int'(hsA), 0);
      wait_cyc(1153); chk("hs_h288", int'(hsA), 1);
      wait_cyc(1277); chk("hs_h319", int'(hsA), 1);
      wait_cyc(1281); chk("hs_h320", int'(hsA), 0);
      wait_cyc(1441); chk("B_frame_start", int'({fsB, lsB}), 3); chk("B_vcnt0", int'(vB), 0);
      wait_cyc(1522); chk("B_hs_h27_f1", int'(hsB), 0);
      wait_cyc(1525);
`ifdef VIDEO_TIMING_GEN_POS_ADJ_EN
      chk("B_hs_h28_f1", int'(hsB), 1);
`else
      chk("B_hs_h28_f1", int'(hsB), 0);
`endif
      wait_cyc(1537); chk("line_start", int'({lsA, fsA}), 2); chk("vcnt_line1", int'(vA), 1);
      wait_cyc(1538); chk("line_start_end", int'(lsA), 0);
      for (int i = 0; i < 8; i++) begin
         repeat ($urandom_range(1500, 3000)) begin
            @(negedge clk);
            if ($urandom_range(0, 199) == 0) begin
               hoffs = 4'($urandom);
               voffs = 4'($urandom);
            end
         end
         reset_pulse();
      end
      repeat (200) @(negedge clk);
      en = 1'b0;
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule

// File: doc/video_timing_gen.md
VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 SHALL have parameter CE_DIV, default 4: clk_sys cycles per pixel, legal range 2..16.
REQ-002 SHALL have parameter H_TOTAL, default 384: pixels per line.
REQ-003 SHALL have parameter H_ACTIVE, default 256: visible pixels per line, less than H_TOTAL.
REQ-004 SHALL have parameters H_SYNC_START and H_SYNC_WIDTH, defaults 288 and 32: hsync position and length in pixels.
REQ-005 SHALL have parameter V_TOTAL, default 262: lines per frame.
REQ-006 SHALL have parameter V_ACTIVE, default 224: visible lines, less than V_TOTAL.
REQ-007 SHALL have parameters V_SYNC_START and V_SYNC_WIDTH, defaults 236 and 3: vsync position and length in lines.
REQ-008 SHALL have port clk_sys, input, 1 bit: the single clock.
REQ-009 SHALL have port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-010 SHALL have port ce_pix, output, 1 bit: pixel clock enable.
REQ-011 SHALL have port hcnt, output, 9 bits: current pixel index.
REQ-012 SHALL have port vcnt, output, 9 bits: current line index.
REQ-013 SHALL have ports HSync, VSync, HBlank and VBlank, outputs, 1 bit each, all positive pulses.
REQ-014 SHALL have port line_start, output, 1 bit: one-cycle pulse at hcnt=0.
REQ-015 SHALL have port frame_start, output, 1 bit: one-cycle pulse at hcnt=0, vcnt=0.
REQ-016 SHALL have ports hoffs and voffs, inputs, 4 bits each, signed two's complement: sync position offsets.

Function
REQ-017 SHALL run a divider counting 0..CE_DIV-1 and register ce_pix high for exactly one clk_sys cycle per CE_DIV cycles.
REQ-018 SHALL produce the first ce_pix pulse in clock cycle CE_DIV after reset_n deasserts.
REQ-019 SHALL increment hcnt on each clock edge where ce_pix=1, wrapping H_TOTAL-1 to 0.
REQ-020 SHALL increment vcnt on the same edge as an hcnt wrap, wrapping V_TOTAL-1 to 0.
REQ-021 SHALL hold hcnt, vcnt and all sync/blank outputs constant between ce_pix pulses.
REQ-022 SHALL register HSync, VSync, HBlank and VBlank on the same edge as hcnt/vcnt, with zero added latency relative to the counters.
REQ-023 SHALL assert HBlank iff hcnt >= H_ACTIVE.
REQ-024 SHALL assert VBlank iff vcnt >= V_ACTIVE.
REQ-025 SHALL assert HSync iff (hcnt - hs_start) mod H_TOTAL < H_SYNC_WIDTH; pulses that cross the line end wrap correctly.
REQ-026 SHALL assert VSync iff (vcnt - vs_start) mod V_TOTAL < V_SYNC_WIDTH; VSync edges therefore coincide with hcnt=0.
REQ-027 SHALL pulse line_start for the first clk_sys cycle in which hcnt=0.
REQ-028 SHALL pulse frame_start for the first clk_sys cycle in which hcnt=0 and vcnt=0; line_start is also high in that cycle.
REQ-029 SHALL compute sync arithmetic at 10-bit width, with no truncation before the modulo.

Reset
REQ-030 SHALL, while reset_n=0, immediately force the divider, hcnt, vcnt, ce_pix, HSync, VSync, HBlank, VBlank, line_start and frame_start to 0, regardless of clock.
REQ-031 SHALL, on reset mid-line or mid-frame, restart timing from hcnt=0, vcnt=0 after release, with no partial sync pulse output.
REQ-032 SHALL reset the latched offsets to 0.

Configuration
REQ-033 SHALL, with macro VIDEO_TIMING_GEN_POS_ADJ_EN defined, set hs_start = (H_SYNC_START + hoffs) mod H_TOTAL and vs_start = (V_SYNC_START + voffs) mod V_TOTAL.
REQ-034 SHALL, with VIDEO_TIMING_GEN_POS_ADJ_EN defined, latch hoffs and voffs only on the edge that loads hcnt=0, vcnt=0; changes made mid-frame take effect at the next frame.
REQ-035 SHALL, without VIDEO_TIMING_GEN_POS_ADJ_EN, ignore hoffs and voffs (ports retained), use hs_start=H_SYNC_START and vs_start=V_SYNC_START, and instantiate no offset registers.

Verification (defaults)
REQ-036 SHALL cover: release reset_n -> first ce_pix in cycle 4, then every 4 cycles, each pulse 1 cycle wide.
REQ-037 SHALL cover: free run -> HBlank rises at hcnt=256, HSync high for hcnt 288..319, line period 1536 clk_sys cycles.
REQ-038 SHALL cover: free run -> VBlank high for vcnt 224..261, VSync high for vcnt 236..238, frame_start every 402432 clk_sys cycles.
REQ-039 SHALL cover: with macro defined, hoffs=-8 and voffs=+2 written mid-frame -> unchanged this frame; next frame HSync covers hcnt 280..311 and VSync covers vcnt 238..240.
REQ-040 SHALL cover: with macro defined, hoffs=+7, H_SYNC_START=380 -> HSync covers hcnt 3..34, with no glitch at the wrap.
REQ-041 SHALL cover: reset_n pulsed low at hcnt=100, vcnt=50 -> all outputs 0 asynchronously; after release the counters restart at 0,0.
